mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single memory bus port between the instruction-fetch path and the load/store path, one transaction outstanding at a time. It captures a winning request, drives the bus request/grant/response handshake, and routes the response or error back to the owner. It also exposes a busy/stall indication so `pc_reg` can hold the PC while a fetch or data access is in flight. A response timeout counter guarantees forward progress on a hung bus.

## Interface
- `XLEN`, 32, data and address width
- `TIMEOUT`, 255, max cycles waiting for `bus_rvalid_i` after grant; 1..255
- `clk` in 1, single clock; all state on rising edge
- `reset` in 1, asynchronous, active-low; clears all state
- `if_req_i` in 1, fetch request; held with address until `if_gnt_o`
- `if_addr_i` in XLEN, fetch address
- `if_gnt_o` out 1, fetch request accepted by bus
- `if_rvalid_o` out 1, fetch response valid, one cycle
- `if_rdata_o` out XLEN, fetch read data
- `if_err_o` out 1, fetch bus error or timeout, qualified by `if_rvalid_o`
- `ls_req_i` in 1, load/store request; held with payload until `ls_gnt_o`
- `ls_we_i` in 1, 1 = store
- `ls_addr_i` in XLEN, data address
- `ls_wdata_i` in XLEN, store data
- `ls_wstrb_i` in 4, byte strobes
- `ls_gnt_o`, `ls_rvalid_o`, `ls_rdata_o`, `ls_err_o` out 1/1/XLEN/1, as the fetch equivalents
- `bus_req_o` out 1, bus request
- `bus_we_o`, `bus_addr_o`, `bus_wdata_o`, `bus_wstrb_o` out 1/XLEN/XLEN/4, registered payload
- `bus_gnt_i` in 1, bus accepts request this cycle
- `bus_rvalid_i` in 1, response valid
- `bus_rdata_i` in XLEN, response data
- `bus_err_i` in 1, response error, qualified by `bus_rvalid_i`
- `busy_o` out 1, state != IDLE
- `stall_o` out 1, `if_req_i & ~if_rvalid_o`; `pc_reg` holds the PC while high

## Operation
- Owner is 1 bit (0 = IF, 1 = LS). `last_ls` is 1 bit and records whether the previous grant went to LS.
- States:
  - IDLE: no transaction.
  - REQ: `bus_req_o` = 1, waiting for `bus_gnt_i`.
  - RESP: waiting for `bus_rvalid_i`.
- Arbitration, evaluated in IDLE, and in RESP on the response cycle:
  - Only one requester: it wins.
  - Both request: LS wins unless `last_ls` = 1, in which case IF wins. LS therefore never takes two consecutive grants while IF waits.
- Capture on entering REQ: the winner's payload is registered onto the `bus_*` outputs and the owner is latched. For fetch, `bus_we_o` = 0, `bus_wdata_o` = 0, `bus_wstrb_o` = 0.
- REQ → RESP when `bus_gnt_i` = 1. That same cycle the owner's `*_gnt_o` = 1 (combinational from `bus_gnt_i` and owner), `last_ls` updates, and the timeout counter loads 0.
- RESP:
  - Counter increments each cycle.
  - On `bus_rvalid_i`: drive the owner's `*_rvalid_o` = 1 and pass `bus_rdata_i`/`bus_err_i` through combinationally. Next state is REQ if any request is pending (back-to-back, new capture), else IDLE.
  - Counter reaches TIMEOUT without `bus_rvalid_i`: owner gets `*_rvalid_o` = 1, `*_err_o` = 1, rdata = 0. Next state follows the same rule as a normal response.
- `bus_rvalid_i` outside RESP (including a late response after a timeout) is ignored.
- Non-owner `*_gnt_o`, `*_rvalid_o` and `*_err_o` are always 0. Non-owner rdata is 0.
- Reset asserted mid-transaction: state returns to IDLE immediately and the transaction is abandoned. The bus is expected to be reset with the core.

## Timing
- Reset values: all outputs 0, state IDLE, `last_ls` = 0, counter 0.
- Minimum latency: request seen in IDLE at cycle 0; `bus_req_o` = 1 at cycle 1; with `bus_gnt_i` in cycle 1, `*_gnt_o` = 1 in cycle 1; earliest `*_rvalid_o` in cycle 2.
- Back-to-back: response in cycle n with a pending request puts `bus_req_o` = 1 in cycle n+1.
- `bus_req_o` and payload stay stable from entering REQ until the grant cycle inclusive.
- Timeout: grant in cycle g with no response gives the error response in cycle g+TIMEOUT.
- A response arriving in the same cycle the counter hits TIMEOUT is taken as a normal response (response wins).

## Test plan
- Single fetch: `if_req_i` = 1, addr 0x100; bus grants at cycle 1, returns 0xDEADBEEF at cycle 3 → `if_gnt_o` = 1 at cycle 1, `if_rvalid_o` = 1 with rdata 0xDEADBEEF at cycle 3, `stall_o` = 1 for cycles 0–2, `busy_o` = 0 at cycle 4.
- Contention: IF and LS both request continuously with 1-cycle bus latency → grants alternate LS, IF, LS, IF; LS store payload addr 0x2000, data 0x55, wstrb 0xF appears on the bus exactly while LS is owner.
- Grant delay: `bus_gnt_i` held low 5 cycles → `bus_req_o` and payload constant all 5 cycles, no `*_gnt_o` until the grant.
- Timeout: TIMEOUT = 4, grant with no response → owner `*_rvalid_o` = 1, `*_err_o` = 1, rdata 0 at grant+4; a later stray `bus_rvalid_i` produces no output.
- Bus error: load returns `bus_err_i` = 1 → `ls_rvalid_o` = 1, `ls_err_o` = 1; `if_*` outputs stay 0.
- Reset mid-RESP: `reset` low while in RESP → all outputs 0 asynchronously; after release, a fresh fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory bus port between instruction
// fetch (IF) and load/store (LS), one transaction outstanding at a time.
// The winner's payload is registered onto the bus. The response, or a
// timeout error, is routed back to the owner. busy/stall outputs let the
// PC register hold while an access is in flight.
module mem_port_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,         // asynchronous, active-low
    // instruction fetch path
    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic            if_gnt_o,
    output logic            if_rvalid_o,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_err_o,
    // load/store path
    input  logic            ls_req_i,
    input  logic            ls_we_i,
    input  logic [XLEN-1:0] ls_addr_i,
    input  logic [XLEN-1:0] ls_wdata_i,
    input  logic [3:0]      ls_wstrb_i,
    output logic            ls_gnt_o,
    output logic            ls_rvalid_o,
    output logic [XLEN-1:0] ls_rdata_o,
    output logic            ls_err_o,
    // memory bus
    output logic            bus_req_o,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [XLEN-1:0] bus_wdata_o,
    output logic [3:0]      bus_wstrb_o,
    input  logic            bus_gnt_i,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    input  logic            bus_err_i,
    // core status
    output logic            busy_o,
    output logic            stall_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value on the cycle that must produce the timeout response.
    // The counter loads 0 on the grant cycle, so grant+TIMEOUT sees TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        owner;     // 0 = IF, 1 = LS
    logic        last_ls;
    logic [7:0]  cnt;

    logic            any_req;
    logic            win_ls;
    logic            grant;
    logic            resp_fire;
    logic            capture;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    // Arbitration, response detection and capture decision
    always_comb begin
        any_req   = if_req_i | ls_req_i;
        win_ls    = ls_req_i & (~if_req_i | ~last_ls);
        grant     = (state == REQ) & bus_gnt_i;
        // a real response in the timeout cycle wins over the timeout error
        resp_fire = (state == RESP) & (bus_rvalid_i | (cnt == CNT_LAST));
        rsp_data  = bus_rvalid_i ? bus_rdata_i : '0;
        rsp_err   = bus_rvalid_i ? bus_err_i : 1'b1;
        capture   = any_req & ((state == IDLE) | resp_fire);
    end

    // State, ownership, timeout counter and registered bus payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_ls     <= 1'b0;
            cnt         <= '0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) state <= REQ;
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        state   <= RESP;
                        last_ls <= owner;
                        cnt     <= '0;
                    end
                end
                RESP: begin
                    cnt <= cnt + 8'd1;
                    if (resp_fire) state <= any_req ? REQ : IDLE;
                end
                default: state <= IDLE;
            endcase
            if (capture) begin
                owner       <= win_ls;
                bus_we_o    <= win_ls & ls_we_i;
                bus_addr_o  <= win_ls ? ls_addr_i : if_addr_i;
                bus_wdata_o <= win_ls ? ls_wdata_i : '0;
                bus_wstrb_o <= win_ls ? ls_wstrb_i : '0;
            end
        end
    end

    // Handshake and response routing to the owner only
    assign bus_req_o   = (state == REQ);
    assign busy_o      = (state != IDLE);
    assign if_gnt_o    = grant & ~owner;
    assign ls_gnt_o    = grant & owner;
    assign if_rvalid_o = resp_fire & ~owner;
    assign ls_rvalid_o = resp_fire & owner;
    assign if_rdata_o  = if_rvalid_o ? rsp_data : '0;
    assign ls_rdata_o  = ls_rvalid_o ? rsp_data : '0;
    assign if_err_o    = if_rvalid_o & rsp_err;
    assign ls_err_o    = ls_rvalid_o & rsp_err;
    // gated by reset so every output reads 0 while reset is held
    assign stall_o     = reset & if_req_i & ~if_rvalid_o;

endmodule
